// File: rtl/des_iterative_core_if.sv
// des_iterative_core_if: block/key handshake bundle for the iterative DES core.
`default_nettype none

interface des_iterative_core_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_block;
  logic [63:0] in_key;
  logic        in_decrypt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_block;
  logic        busy;
  logic        key_err;

  modport master (
    output in_valid, in_block, in_key, in_decrypt, out_ready,
    input  in_ready, out_valid, out_block, busy, key_err
  );

  modport slave (
    input  in_valid, in_block, in_key, in_decrypt, out_ready,
    output in_ready, out_valid, out_block, busy, key_err
  );
endinterface

`default_nettype wire

// File: rtl/des_iterative_core.sv
// des_iterative_core: iterative DES encrypt/decrypt, ROUNDS_PER_CYCLE rounds per clock, on-the-fly key schedule.
// Optional key-byte odd-parity flag enabled by defining DES_KEY_PARITY_CHECK_EN.
`default_nettype none

module des_iterative_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  wire                  clk,
  input  wire                  rst_n,
  des_iterative_core_if.slave  bus
);
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
    64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5,
    63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
    37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26,
    33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9,
    19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
    19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam logic [3:0] SBOX [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  localparam logic [4:0] LAST = 5'(16 / ROUNDS_PER_CYCLE);

  if (!(ROUNDS_PER_CYCLE inside {1, 2, 4, 8, 16})) begin : g_bad_rounds_per_cycle
    $error("des_iterative_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Tables use DES numbering: bit 1 is the MSB of the source vector.
  function automatic logic [63:0] f_ip(input logic [63:0] x);
    f_ip = '0;
    for (int k = 0; k < 64; k++) f_ip[63-k] = x[64-IP_T[k]];
  endfunction
  function automatic logic [63:0] f_fp(input logic [63:0] x);
    f_fp = '0;
    for (int k = 0; k < 64; k++) f_fp[63-k] = x[64-FP_T[k]];
  endfunction
  function automatic logic [55:0] f_pc1(input logic [63:0] x);
    f_pc1 = '0;
    for (int k = 0; k < 56; k++) f_pc1[55-k] = x[64-PC1_T[k]];
  endfunction
  function automatic logic [47:0] f_pc2(input logic [55:0] x);
    f_pc2 = '0;
    for (int k = 0; k < 48; k++) f_pc2[47-k] = x[56-PC2_T[k]];
  endfunction

  function automatic logic [31:0] f_feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  b;
    x = '0;
    for (int n = 0; n < 48; n++) x[47-n] = r[32-E_T[n]];
    x = x ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      b = x[47-6*i -: 6];
      s[31-4*i -: 4] = SBOX[i*64 + int'({b[5], b[0], b[4:1]})];
    end
    p = '0;
    for (int n = 0; n < 32; n++) p[31-n] = s[32-P_T[n]];
    f_feistel = p;
  endfunction

  // Decrypt rotates right before forming the subkey, walking C/D back from K16 to K1.
  function automatic logic [1:0] f_shift(input logic [4:0] idx, input logic dec);
    if (dec) f_shift = (idx == 5'd1) ? 2'd0 : (idx == 5'd2 || idx == 5'd9 || idx == 5'd16) ? 2'd1 : 2'd2;
    else     f_shift = (idx == 5'd1 || idx == 5'd2 || idx == 5'd9 || idx == 5'd16) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] f_rot(input logic [27:0] v, input logic [1:0] n, input logic dec);
    case ({dec, n})
      3'b001:  f_rot = {v[26:0], v[27]};
      3'b010:  f_rot = {v[25:0], v[27:26]};
      3'b101:  f_rot = {v[0], v[27:1]};
      3'b110:  f_rot = {v[1:0], v[27:2]};
      default: f_rot = v;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_dec;
  logic [31:0] r_l, r_r;
  logic [27:0] r_c, r_d;
  logic        r_out_valid;
  logic [63:0] r_out_block;
  logic [63:0] w_ip;
  logic [55:0] w_pc1;

  logic [31:0] w_l [ROUNDS_PER_CYCLE+1];
  logic [31:0] w_r [ROUNDS_PER_CYCLE+1];
  logic [27:0] w_c [ROUNDS_PER_CYCLE+1];
  logic [27:0] w_d [ROUNDS_PER_CYCLE+1];

  assign w_ip  = f_ip(bus.in_block);
  assign w_pc1 = f_pc1(bus.in_key);
  assign w_l[0] = r_l;
  assign w_r[0] = r_r;
  assign w_c[0] = r_c;
  assign w_d[0] = r_d;

  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
    logic [4:0]  idx;
    logic [1:0]  sh;
    logic [47:0] subkey;
    assign idx         = r_cnt * 5'(ROUNDS_PER_CYCLE) + 5'(j + 1);
    assign sh          = f_shift(idx, r_dec);
    assign w_c[j+1]    = f_rot(w_c[j], sh, r_dec);
    assign w_d[j+1]    = f_rot(w_d[j], sh, r_dec);
    assign subkey      = f_pc2({w_c[j+1], w_d[j+1]});
    assign w_l[j+1]    = w_r[j];
    assign w_r[j+1]    = w_l[j] ^ f_feistel(w_r[j], subkey);
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic r_key_err;
  logic w_key_err;
  always_comb begin
    w_key_err = 1'b0;
    for (int b = 0; b < 8; b++) w_key_err = w_key_err | ~(^bus.in_key[8*b +: 8]);
  end
  assign bus.key_err = r_key_err;
`else
  assign bus.key_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 5'd0;
      r_dec       <= 1'b0;
      r_l         <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_out_valid <= 1'b0;
      r_out_block <= '0;
`ifdef DES_KEY_PARITY_CHECK_EN
      r_key_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_l     <= w_ip[63:32];
          r_r     <= w_ip[31:0];
          r_c     <= w_pc1[55:28];
          r_d     <= w_pc1[27:0];
          r_dec   <= bus.in_decrypt;
          r_cnt   <= 5'd0;
          r_state <= RUN;
`ifdef DES_KEY_PARITY_CHECK_EN
          r_key_err <= w_key_err;
`endif
        end
        RUN: begin
          r_l   <= w_l[ROUNDS_PER_CYCLE];
          r_r   <= w_r[ROUNDS_PER_CYCLE];
          r_c   <= w_c[ROUNDS_PER_CYCLE];
          r_d   <= w_d[ROUNDS_PER_CYCLE];
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt + 5'd1 == LAST) begin
            r_out_block <= f_fp({w_r[ROUNDS_PER_CYCLE], w_l[ROUNDS_PER_CYCLE]});
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_block = r_out_block;

endmodule

`default_nettype wire

// File: tb/tb_des_iterative_core.sv
// tb_des_iterative_core: drives four cores (1, 2, 4, 16 rounds/clock) in lockstep with known DES vectors.
`default_nettype none

module tb_des_iterative_core;
  localparam int RPC [4] = '{1, 2, 4, 16};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_block = '0;
  logic [63:0] in_key = '0;
  logic        in_decrypt = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  dut_in_ready, dut_out_valid, dut_busy, dut_key_err;
  logic [63:0] dut_out_block [4];

  int          n_tests = 0;
  int          n_fail = 0;
  int          lat [4];
  int          nout [4];
  logic [63:0] res [4];
  bit          rdy_err [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_iterative_core_if bus ();
    des_iterative_core #(.ROUNDS_PER_CYCLE(RPC[g])) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign bus.in_valid      = in_valid;
    assign bus.in_block      = in_block;
    assign bus.in_key        = in_key;
    assign bus.in_decrypt    = in_decrypt;
    assign bus.out_ready     = out_ready;
    assign dut_in_ready[g]   = bus.in_ready;
    assign dut_out_valid[g]  = bus.out_valid;
    assign dut_busy[g]       = bus.busy;
    assign dut_key_err[g]    = bus.key_err;
    assign dut_out_block[g]  = bus.out_block;
  end

  // Issue one block to all cores and watch 20 cycles; garbage in_valid pulse / input changes optional.
  task automatic run_vector(input logic [63:0] key, input logic [63:0] blk, input logic dec,
                            input bit pulse, input bit corrupt);
    @(negedge clk);
    in_key = key; in_block = blk; in_decrypt = dec; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int d = 0; d < 4; d++) begin lat[d] = 0; nout[d] = 0; res[d] = 'x; rdy_err[d] = 0; end
    for (int c = 1; c <= 20; c++) begin
      if (pulse && c == 2) begin in_valid = 1'b1; in_block = ~blk; end
      if (pulse && c == 3) in_valid = 1'b0;
      if (corrupt && c == 2) begin in_key = ~key; in_block = ~blk; in_decrypt = ~dec; end
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++) begin
        if (dut_out_valid[d]) begin
          if (nout[d] == 0) begin lat[d] = c; res[d] = dut_out_block[d]; end
          nout[d]++;
          if (dut_in_ready[d]) rdy_err[d] = 1;
        end else if (nout[d] == 0 && dut_in_ready[d]) rdy_err[d] = 1;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      n_tests++;
      if ({dut_in_ready[d], dut_out_valid[d], dut_busy[d], dut_key_err[d]} !== 4'b1000 ||
          dut_out_block[d] !== 64'h0) begin
        n_fail++;
        $display("FAIL reset dut%0d: got rdy/vld/busy/kerr=%b%b%b%b blk=%h, expected 1000 blk=0",
                 d, dut_in_ready[d], dut_out_valid[d], dut_busy[d], dut_key_err[d], dut_out_block[d]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_vector(input string name, input logic [63:0] key, input logic [63:0] blk,
                             input logic dec, input logic [63:0] exp);
    run_vector(key, blk, dec, 1'b1, 1'b0);
    for (int d = 0; d < 4; d++) begin
      n_tests++;
      if (res[d] !== exp) begin
        n_fail++;
        $display("FAIL %s result dut%0d: got %h expected %h", name, d, res[d], exp);
      end
      n_tests++;
      if (lat[d] !== 16 / RPC[d] || nout[d] !== 1 || rdy_err[d]) begin
        n_fail++;
        $display("FAIL %s timing dut%0d: latency %0d outputs %0d ready_err %0d, expected latency %0d outputs 1 ready_err 0",
                 name, d, lat[d], nout[d], rdy_err[d], 16 / RPC[d]);
      end
    end
  endtask

  task automatic test_backpressure;
    bit stable_err [4];
    out_ready = 1'b0;
    run_vector(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 1'b0, 1'b1);
    for (int d = 0; d < 4; d++) stable_err[d] = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++)
        if (!dut_out_valid[d] || dut_out_block[d] !== 64'h85E813540F0AB405 || dut_in_ready[d] || !dut_busy[d])
          stable_err[d] = 1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) begin
      n_tests++;
      if (res[d] !== 64'h85E813540F0AB405 || lat[d] !== 16 / RPC[d]) begin
        n_fail++;
        $display("FAIL bp_result dut%0d: got %h latency %0d, expected 85e813540f0ab405 latency %0d",
                 d, res[d], lat[d], 16 / RPC[d]);
      end
      n_tests++;
      if (stable_err[d] || rdy_err[d]) begin
        n_fail++;
        $display("FAIL bp_hold dut%0d: got hold_err %0d ready_err %0d, expected 0 0", d, stable_err[d], rdy_err[d]);
      end
      n_tests++;
      if (dut_out_valid[d] !== 1'b0 || dut_in_ready[d] !== 1'b1 || dut_out_block[d] !== 64'h85E813540F0AB405) begin
        n_fail++;
        $display("FAIL bp_handoff dut%0d: got vld %b rdy %b blk %h, expected vld 0 rdy 1 blk 85e813540f0ab405",
                 d, dut_out_valid[d], dut_in_ready[d], dut_out_block[d]);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    in_key = 64'h133457799BBCDFF1; in_block = 64'h0123456789ABCDEF; in_decrypt = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      n_tests++;
      if ({dut_in_ready[d], dut_out_valid[d], dut_busy[d]} !== 3'b100 || dut_out_block[d] !== 64'h0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: got rdy/vld/busy=%b%b%b blk=%h, expected 100 blk=0",
                 d, dut_in_ready[d], dut_out_valid[d], dut_busy[d], dut_out_block[d]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    test_vector("post_reset", 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF);
  endtask

  task automatic test_parity;
    logic exp_err;
`ifdef DES_KEY_PARITY_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    test_vector("parity_even_key", 64'h133457799BBCDFF0, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405);
    for (int d = 0; d < 4; d++) begin
      n_tests++;
      if (dut_key_err[d] !== exp_err) begin
        n_fail++;
        $display("FAIL key_err_even dut%0d: got %b expected %b", d, dut_key_err[d], exp_err);
      end
    end
    test_vector("parity_odd_key", 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405);
    for (int d = 0; d < 4; d++) begin
      n_tests++;
      if (dut_key_err[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL key_err_odd dut%0d: got %b expected 0", d, dut_key_err[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vector("encrypt", 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405);
    test_vector("decrypt", 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF);
    test_vector("encrypt_zero", 64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000);
    test_backpressure();
    test_reset_mid_run();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
